router_gate_ctrl: RTL and testbench



---
 rtl/pronoc_pkg.sv | 19 +
 rtl/pronoc_register.sv | 17 +
 rtl/router_gate_stats.sv | 49 ++++
 rtl/router_gate_ctrl.sv | 142 ++++++++++++++
 tb/tb_router_gate_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pronoc_pkg.sv
// Shared NoC types: router event bundle plus the clock-gating sequencer state and stats widths.
package pronoc_pkg;

  typedef struct packed {
    logic flit_wr_i;
    logic empty;
  } router_event_t;

  typedef enum logic [1:0] {
    GATE_ACTIVE = 2'd0,
    GATE_DRAIN  = 2'd1,
    GATE_GATED  = 2'd2,
    GATE_WAKE   = 2'd3
  } gate_state_t;

  localparam int GATE_STAT_W = 32;
  localparam int GATE_EVT_W  = 16;

endpackage

// File: rtl/pronoc_register.sv
// Generic state flop with synchronous active-high reset to a parameterised value.
module pronoc_register #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (reset) q_o <= RST_VAL;
    else       q_o <= d_i;
  end

endmodule

// File: rtl/router_gate_stats.sv
// Saturating gating statistics: cycles spent gated and number of gate entries; cleared only by reset.
module router_gate_stats
  import pronoc_pkg::*;
#(
  parameter int CYC_W = GATE_STAT_W,
  parameter int EVT_W = GATE_EVT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gated_i,
  input  logic             gate_event_i,
  output logic [CYC_W-1:0] gated_cycles_o,
  output logic [EVT_W-1:0] gate_events_o
);

  function automatic logic [CYC_W-1:0] sat_inc_cyc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + CYC_W'(1);
  endfunction

  function automatic logic [EVT_W-1:0] sat_inc_evt(input logic [EVT_W-1:0] v);
    return (&v) ? v : v + EVT_W'(1);
  endfunction

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [EVT_W-1:0] evt_q, evt_d;

  always_comb begin
    cyc_d = gated_i      ? sat_inc_cyc(cyc_q) : cyc_q;
    evt_d = gate_event_i ? sat_inc_evt(evt_q) : evt_q;
  end

  pronoc_register #(.W(CYC_W), .RST_VAL('0)) u_cyc_reg (
    .clk   (clk),
    .reset (reset),
    .d_i   (cyc_d),
    .q_o   (cyc_q)
  );

  pronoc_register #(.W(EVT_W), .RST_VAL('0)) u_evt_reg (
    .clk   (clk),
    .reset (reset),
    .d_i   (evt_d),
    .q_o   (evt_q)
  );

  assign gated_cycles_o = cyc_q;
  assign gate_events_o  = evt_q;

endmodule

// File: rtl/router_gate_ctrl.sv
// Per-router idle detection and clock-gating sequencer (ACTIVE -> DRAIN -> GATED -> WAKE).
// Define ROUTER_GATE_STATS_EN to build the saturating gated-cycle / gate-event counters.
module router_gate_ctrl
  import pronoc_pkg::*;
#(
  parameter int P         = 5,
  parameter int IDLE_TH   = 16,
  parameter int DRAIN_CYC = 3,
  parameter int WAKE_CYC  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sleep_en_i,
  input  router_event_t [P-1:0]  router_event,
  input  logic [P-1:0]           wake_req_i,
  output logic                   clk_en_o,
  output logic [P-1:0]           port_ready_o,
  output logic                   gated_o,
  output logic [GATE_STAT_W-1:0] gated_cycles_o,
  output logic [GATE_EVT_W-1:0]  gate_events_o
);

  localparam int IDLE_W  = $clog2(IDLE_TH + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);
  localparam int WAKE_W  = $clog2(WAKE_CYC + 1);

  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TH - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
  localparam logic [WAKE_W-1:0]  WAKE_LAST  = WAKE_W'(WAKE_CYC - 1);

  logic              all_quiet;
  logic              idle;
  logic [1:0]        state_raw_q;
  gate_state_t       state_q, state_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [WAKE_W-1:0]  wake_cnt_q, wake_cnt_d;

  always_comb begin
    all_quiet = 1'b1;
    for (int k = 0; k < P; k++) begin
      all_quiet = all_quiet & router_event[k].empty & ~router_event[k].flit_wr_i;
    end
  end

  assign idle = ~|wake_req_i & all_quiet;

  pronoc_register #(.W(2), .RST_VAL(GATE_ACTIVE)) u_state_reg (
    .clk   (clk),
    .reset (reset),
    .d_i   (state_d),
    .q_o   (state_raw_q)
  );

  assign state_q = gate_state_t'(state_raw_q);

  // In GATED the router is frozen, so only wake requests and sleep_en_i are looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      GATE_ACTIVE: if (idle && sleep_en_i && idle_cnt_q == IDLE_LAST) state_d = GATE_DRAIN;
      GATE_DRAIN: begin
        if (!idle || !sleep_en_i)        state_d = GATE_ACTIVE;
        else if (drain_cnt_q == DRAIN_LAST) state_d = GATE_GATED;
      end
      GATE_GATED:  if (|wake_req_i || !sleep_en_i) state_d = GATE_WAKE;
      GATE_WAKE:   if (wake_cnt_q == WAKE_LAST)     state_d = GATE_ACTIVE;
      default:     state_d = GATE_ACTIVE;
    endcase
  end

  // Counters only advance while staying in their own state, which clears them on every entry.
  // idle_cnt holds at its last value so a long run with sleep disabled cannot wrap.
  always_comb begin
    idle_cnt_d  = '0;
    drain_cnt_d = '0;
    wake_cnt_d  = '0;
    if (state_q == GATE_ACTIVE && state_d == GATE_ACTIVE && idle) begin
      idle_cnt_d = (idle_cnt_q == IDLE_LAST) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
    end
    if (state_q == GATE_DRAIN && state_d == GATE_DRAIN) begin
      drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
    end
    if (state_q == GATE_WAKE && state_d == GATE_WAKE) begin
      wake_cnt_d = wake_cnt_q + WAKE_W'(1);
    end
  end

  pronoc_register #(.W(IDLE_W), .RST_VAL('0)) u_idle_cnt_reg (
    .clk   (clk),
    .reset (reset),
    .d_i   (idle_cnt_d),
    .q_o   (idle_cnt_q)
  );

  pronoc_register #(.W(DRAIN_W), .RST_VAL('0)) u_drain_cnt_reg (
    .clk   (clk),
    .reset (reset),
    .d_i   (drain_cnt_d),
    .q_o   (drain_cnt_q)
  );

  pronoc_register #(.W(WAKE_W), .RST_VAL('0)) u_wake_cnt_reg (
    .clk   (clk),
    .reset (reset),
    .d_i   (wake_cnt_d),
    .q_o   (wake_cnt_q)
  );

  always_comb begin
    clk_en_o     = 1'b1;
    port_ready_o = '0;
    gated_o      = 1'b0;
    case (state_q)
      GATE_ACTIVE: port_ready_o = '1;
      GATE_GATED: begin
        clk_en_o = 1'b0;
        gated_o  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ROUTER_GATE_STATS_EN
  logic gate_event;

  assign gate_event = (state_q == GATE_DRAIN) && (state_d == GATE_GATED);

  router_gate_stats #(.CYC_W(GATE_STAT_W), .EVT_W(GATE_EVT_W)) u_stats (
    .clk            (clk),
    .reset          (reset),
    .gated_i        (gated_o),
    .gate_event_i   (gate_event),
    .gated_cycles_o (gated_cycles_o),
    .gate_events_o  (gate_events_o)
  );
`else
  assign gated_cycles_o = '0;
  assign gate_events_o  = '0;
`endif

endmodule

// File: tb/tb_router_gate_ctrl.sv
// Self-checking bench for router_gate_ctrl: directed scenarios plus randomized traffic vs a cycle model.
module tb_router_gate_ctrl;
  import pronoc_pkg::*;

  localparam int P         = 5;
  localparam int IDLE_TH   = 16;
  localparam int DRAIN_CYC = 3;
  localparam int WAKE_CYC  = 2;
`ifdef ROUTER_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int M_ACTIVE = 0;
  localparam int M_DRAIN  = 1;
  localparam int M_GATED  = 2;
  localparam int M_WAKE   = 3;

  localparam logic [P-1:0] NONE = '0;
  localparam logic [P-1:0] ALL  = '1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  sleep_en_i;
  router_event_t [P-1:0] router_event;
  logic [P-1:0]          wake_req_i;
  logic                  clk_en_o;
  logic [P-1:0]          port_ready_o;
  logic                  gated_o;
  logic [31:0]           gated_cycles_o;
  logic [15:0]           gate_events_o;

  router_gate_ctrl #(
    .P(P), .IDLE_TH(IDLE_TH), .DRAIN_CYC(DRAIN_CYC), .WAKE_CYC(WAKE_CYC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sleep_en_i     (sleep_en_i),
    .router_event   (router_event),
    .wake_req_i     (wake_req_i),
    .clk_en_o       (clk_en_o),
    .port_ready_o   (port_ready_o),
    .gated_o        (gated_o),
    .gated_cycles_o (gated_cycles_o),
    .gate_events_o  (gate_events_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode, consecutive idle cycles seen while awake, cycles spent in DRAIN/WAKE.
  int     m_mode;
  int     m_run;
  int     m_t;
  longint m_gcyc;
  int     m_gev;

  logic [P+49:0] obs_all;
  assign obs_all = {clk_en_o, port_ready_o, gated_o, gated_cycles_o, gate_events_o};

  function automatic logic [P+1:0] exp_ctl();
    case (m_mode)
      M_ACTIVE: return {1'b1, {P{1'b1}}, 1'b0};
      M_GATED:  return {1'b0, {P{1'b0}}, 1'b1};
      default:  return {1'b1, {P{1'b0}}, 1'b0};
    endcase
  endfunction

  function automatic logic [P+49:0] exp_all();
    logic [31:0] gc;
    logic [15:0] ge;
    gc = STATS ? m_gcyc[31:0] : 32'd0;
    ge = STATS ? m_gev[15:0]  : 16'd0;
    return {exp_ctl(), gc, ge};
  endfunction

  task automatic model_step(input logic rst, input logic sleep, input logic [P-1:0] wr,
                            input logic [P-1:0] emp, input logic [P-1:0] wk);
    bit idle;
    idle = (wk == '0);
    for (int k = 0; k < P; k++) begin
      if (!emp[k] || wr[k]) idle = 1'b0;
    end
    if (rst) begin
      m_mode = M_ACTIVE; m_run = 0; m_t = 0; m_gcyc = 0; m_gev = 0;
      return;
    end
    if (m_mode == M_GATED && m_gcyc < 64'hFFFF_FFFF) m_gcyc++;
    case (m_mode)
      M_ACTIVE: begin
        m_run = idle ? m_run + 1 : 0;
        if (idle && sleep && m_run >= IDLE_TH) begin m_mode = M_DRAIN; m_t = 0; end
      end
      M_DRAIN: begin
        if (!idle || !sleep) begin
          m_mode = M_ACTIVE; m_run = 0;
        end else begin
          m_t++;
          if (m_t >= DRAIN_CYC) begin
            m_mode = M_GATED;
            if (m_gev < 65535) m_gev++;
          end
        end
      end
      M_GATED: if (wk != '0 || !sleep) begin m_mode = M_WAKE; m_t = 0; end
      default: begin
        m_t++;
        if (m_t >= WAKE_CYC) begin m_mode = M_ACTIVE; m_run = 0; end
      end
    endcase
  endtask

  // Drive one cycle's inputs, clock it, advance the model, and settle just after the edge.
  task automatic tick(input logic rst, input logic sleep, input logic [P-1:0] wr,
                      input logic [P-1:0] emp, input logic [P-1:0] wk);
    reset      = rst;
    sleep_en_i = sleep;
    wake_req_i = wk;
    for (int k = 0; k < P; k++) begin
      router_event[k].flit_wr_i = wr[k];
      router_event[k].empty     = emp[k];
    end
    @(posedge clk);
    model_step(rst, sleep, wr, emp, wk);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, NONE, ALL, NONE);
    checks++;
    if ({clk_en_o, port_ready_o, gated_o} !== {1'b1, ALL, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=%b", {clk_en_o, port_ready_o, gated_o}, {1'b1, ALL, 1'b0});
    end
    checks++;
    if ({gated_cycles_o, gate_events_o} !== 48'd0) begin
      errors++;
      $display("FAIL reset_stats got=%h exp=0", {gated_cycles_o, gate_events_o});
    end
  endtask

  task automatic test_idle_run();
    tick(1'b1, 1'b1, NONE, ALL, NONE);
    for (int c = 1; c <= 22; c++) begin
      tick(1'b0, 1'b1, NONE, ALL, NONE);
      checks++;
      if (obs_all !== exp_all()) begin
        errors++;
        $display("FAIL idle_run_model cyc=%0d got=%h exp=%h", c, obs_all, exp_all());
      end
      if (c == 15) begin
        checks++;
        if (port_ready_o !== ALL) begin
          errors++;
          $display("FAIL idle_run_ready15 got=%b exp=%b", port_ready_o, ALL);
        end
      end
      if (c == 16) begin
        checks++;
        if ({clk_en_o, port_ready_o} !== {1'b1, NONE}) begin
          errors++;
          $display("FAIL idle_run_drain16 got=%b exp=%b", {clk_en_o, port_ready_o}, {1'b1, NONE});
        end
      end
      if (c == 19) begin
        checks++;
        if ({clk_en_o, gated_o, gate_events_o} !== {1'b0, 1'b1, (STATS ? 16'd1 : 16'd0)}) begin
          errors++;
          $display("FAIL idle_run_gated19 got=%b/%b/%0d exp=0/1/%0d", clk_en_o, gated_o,
                   gate_events_o, STATS ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_broken_idle();
    tick(1'b1, 1'b1, NONE, ALL, NONE);
    for (int c = 1; c <= 30; c++) begin
      tick(1'b0, 1'b1, (c - 1 == 10) ? 5'b00100 : NONE, ALL, NONE);
      checks++;
      if (obs_all !== exp_all()) begin
        errors++;
        $display("FAIL broken_idle_model cyc=%0d got=%h exp=%h", c, obs_all, exp_all());
      end
      if (c == 16 || c == 26) begin
        checks++;
        if (port_ready_o !== ALL) begin
          errors++;
          $display("FAIL broken_idle_ready cyc=%0d got=%b exp=%b", c, port_ready_o, ALL);
        end
      end
      if (c == 27) begin
        checks++;
        if (port_ready_o !== NONE) begin
          errors++;
          $display("FAIL broken_idle_drain27 got=%b exp=%b", port_ready_o, NONE);
        end
      end
    end
  endtask

  task automatic test_abort_drain();
    tick(1'b1, 1'b1, NONE, ALL, NONE);
    for (int c = 1; c <= 24; c++) begin
      tick(1'b0, 1'b1, NONE, ALL, (c - 1 == 17) ? 5'b00010 : NONE);
      checks++;
      if (obs_all !== exp_all()) begin
        errors++;
        $display("FAIL abort_model cyc=%0d got=%h exp=%h", c, obs_all, exp_all());
      end
      if (c == 17) begin
        checks++;
        if (port_ready_o !== NONE) begin
          errors++;
          $display("FAIL abort_drain17 got=%b exp=%b", port_ready_o, NONE);
        end
      end
      if (c >= 18) begin
        checks++;
        if ({clk_en_o, port_ready_o, gated_o} !== {1'b1, ALL, 1'b0}) begin
          errors++;
          $display("FAIL abort_active cyc=%0d got=%b exp=%b", c,
                   {clk_en_o, port_ready_o, gated_o}, {1'b1, ALL, 1'b0});
        end
      end
    end
  endtask

  task automatic test_wake();
    tick(1'b1, 1'b1, NONE, ALL, NONE);
    for (int c = 1; c <= 30; c++) begin
      tick(1'b0, 1'b1, NONE, ALL, (c - 1 == 23) ? 5'b01000 : NONE);
      checks++;
      if (obs_all !== exp_all()) begin
        errors++;
        $display("FAIL wake_model cyc=%0d got=%h exp=%h", c, obs_all, exp_all());
      end
      if (c == 24 || c == 25) begin
        checks++;
        if ({clk_en_o, port_ready_o, gated_o} !== {1'b1, NONE, 1'b0}) begin
          errors++;
          $display("FAIL wake_phase cyc=%0d got=%b exp=%b", c,
                   {clk_en_o, port_ready_o, gated_o}, {1'b1, NONE, 1'b0});
        end
      end
      if (c == 26) begin
        checks++;
        if ({port_ready_o, gated_cycles_o} !== {ALL, (STATS ? 32'd5 : 32'd0)}) begin
          errors++;
          $display("FAIL wake_ready26 got=%b/%0d exp=%b/%0d", port_ready_o, gated_cycles_o,
                   ALL, STATS ? 5 : 0);
        end
      end
    end
  endtask

  task automatic test_sleep_disabled();
    tick(1'b1, 1'b0, NONE, ALL, NONE);
    for (int c = 1; c <= 100; c++) begin
      tick(1'b0, 1'b0, NONE, ALL, NONE);
      checks++;
      if ({clk_en_o, port_ready_o, gated_o} !== {1'b1, ALL, 1'b0}) begin
        errors++;
        $display("FAIL sleep_off_active cyc=%0d got=%b", c, {clk_en_o, port_ready_o, gated_o});
      end
    end
    for (int c = 101; c <= 120; c++) begin
      tick(1'b0, 1'b1, NONE, ALL, NONE);
      checks++;
      if (obs_all !== exp_all()) begin
        errors++;
        $display("FAIL sleep_on_model cyc=%0d got=%h exp=%h", c, obs_all, exp_all());
      end
    end
    checks++;
    if (gated_o !== 1'b1) begin
      errors++;
      $display("FAIL sleep_on_gated got=%b exp=1", gated_o);
    end
    tick(1'b0, 1'b0, NONE, ALL, NONE);
    checks++;
    if ({clk_en_o, port_ready_o, gated_o} !== {1'b1, NONE, 1'b0}) begin
      errors++;
      $display("FAIL sleep_drop_wake got=%b exp=%b", {clk_en_o, port_ready_o, gated_o},
               {1'b1, NONE, 1'b0});
    end
    tick(1'b0, 1'b0, NONE, ALL, NONE);
    tick(1'b0, 1'b0, NONE, ALL, NONE);
    checks++;
    if (obs_all !== exp_all() || port_ready_o !== ALL) begin
      errors++;
      $display("FAIL sleep_drop_active got=%h exp=%h", obs_all, exp_all());
    end
  endtask

  task automatic test_reset_gated();
    tick(1'b1, 1'b1, NONE, ALL, NONE);
    for (int c = 1; c <= 25; c++) tick(1'b0, 1'b1, NONE, ALL, NONE);
    checks++;
    if ({gated_o, gated_cycles_o} !== {1'b1, (STATS ? 32'd6 : 32'd0)}) begin
      errors++;
      $display("FAIL rst_gated_pre got=%b/%0d exp=1/%0d", gated_o, gated_cycles_o, STATS ? 6 : 0);
    end
    tick(1'b1, 1'b1, NONE, ALL, NONE);
    checks++;
    if (obs_all !== {1'b1, ALL, 1'b0, 48'd0}) begin
      errors++;
      $display("FAIL rst_gated_post got=%h exp=%h", obs_all, {1'b1, ALL, 1'b0, 48'd0});
    end
    tick(1'b0, 1'b1, NONE, ALL, NONE);
    checks++;
    if (obs_all !== exp_all()) begin
      errors++;
      $display("FAIL rst_gated_after got=%h exp=%h", obs_all, exp_all());
    end
  endtask

  task automatic test_random();
    logic [P-1:0] wr, emp, wk;
    logic         rst, sleep;
    tick(1'b1, 1'b1, NONE, ALL, NONE);
    for (int c = 1; c <= 4000; c++) begin
      rst   = ($urandom_range(999) == 0);
      sleep = ($urandom_range(99) != 0);
      for (int k = 0; k < P; k++) begin
        wr[k]  = ($urandom_range(299) == 0);
        emp[k] = ($urandom_range(299) != 0);
        wk[k]  = ($urandom_range(299) == 0);
      end
      tick(rst, sleep, wr, emp, wk);
      checks++;
      if (obs_all !== exp_all()) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%h exp=%h", c, obs_all, exp_all());
      end
    end
  endtask

  initial begin
    m_mode = M_ACTIVE; m_run = 0; m_t = 0; m_gcyc = 0; m_gev = 0;
    test_reset();
    test_idle_run();
    test_broken_idle();
    test_abort_drain();
    test_wake();
    test_sleep_disabled();
    test_reset_gated();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
